// File: rtl/rom_loader_pkg.sv
// Shared CPU/loader definitions: ROM geometry, bus widths, loader framing and FSM states.
package rom_loader_pkg;

   localparam int unsigned ROM_NUM       = 4096;
   localparam int unsigned INST_ADDR_BUS = 32;
   localparam int unsigned INST_DATA_BUS = 32;

   localparam logic [7:0] LOADER_HEADER = 8'hA5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4
   } loader_state_t;

endpackage

// File: rtl/rom_loader_if.sv
// UART byte stream in, ROM write port and status pulses out.
interface rom_loader_if;
   import rom_loader_pkg::*;

   logic                     rx_valid_i;
   logic [7:0]               rx_data_i;
   logic                     wr_en_o;
   logic [INST_ADDR_BUS-1:0] wr_addr_o;
   logic [INST_DATA_BUS-1:0] wr_data_o;
   logic                     busy_o;
   logic                     cpu_hold_o;
   logic                     done_o;
   logic                     err_o;

   modport master (
      input  rx_valid_i, rx_data_i,
      output wr_en_o, wr_addr_o, wr_data_o, busy_o, cpu_hold_o, done_o, err_o
   );

   modport slave (
      output rx_valid_i, rx_data_i,
      input  wr_en_o, wr_addr_o, wr_data_o, busy_o, cpu_hold_o, done_o, err_o
   );

endinterface

// File: rtl/rom_loader_timeout.sv
// Idle-gap watchdog for serial receivers: expire fires when no kick arrives for TIMEOUT_CYCLES.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic kick,
   output logic expire
);

   logic [31:0] count;

   // A kick in the expiry cycle suppresses expire, so the byte always wins.
   assign expire = enable && !kick && (count == TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!enable || kick) begin
         count <= '0;
      end else if (!expire) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/rom_loader.sv
// Serial program downloader: parses HEADER/LEN/words/CSUM packets and writes words into the ROM.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter logic [7:0]  HEADER         = LOADER_HEADER,
   parameter int unsigned MAX_WORDS      = ROM_NUM,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input logic           sys_clk,
   input logic           sys_rst_n,
   rom_loader_if.master  bus
);

   loader_state_t            state, state_n;
   logic [15:0]              len, len_n, len_full;
   logic [15:0]              word_cnt, word_cnt_n;
   logic [1:0]               byte_idx, byte_idx_n;
   logic [31:0]              word, word_n;
   logic [7:0]               csum, csum_n;
   logic                     wr_en, wr_en_n;
   logic [INST_ADDR_BUS-1:0] wr_addr, wr_addr_n;
   logic [INST_DATA_BUS-1:0] wr_data, wr_data_n;
   logic                     busy, busy_n;
   logic                     done, done_n;
   logic                     err, err_n;
   logic                     expire;

   loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .enable (state != IDLE),
      .kick   (bus.rx_valid_i),
      .expire (expire)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         len      <= '0;
         word_cnt <= '0;
         byte_idx <= '0;
         word     <= '0;
         csum     <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         len      <= len_n;
         word_cnt <= word_cnt_n;
         byte_idx <= byte_idx_n;
         word     <= word_n;
         csum     <= csum_n;
         wr_en    <= wr_en_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      len_n      = len;
      len_full   = {bus.rx_data_i, len[7:0]};
      word_cnt_n = word_cnt;
      byte_idx_n = byte_idx;
      word_n     = word;
      csum_n     = csum;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      busy_n     = busy;
      done_n     = 1'b0;
      err_n      = 1'b0;

      if (expire) begin
         state_n = IDLE;
         busy_n  = 1'b0;
         err_n   = 1'b1;
      end else if (bus.rx_valid_i) begin
         unique case (state)
            IDLE: begin
               if (bus.rx_data_i == HEADER) begin
                  state_n    = LEN_LO;
                  busy_n     = 1'b1;
                  csum_n     = '0;
                  word_cnt_n = '0;
                  byte_idx_n = '0;
               end
            end
            LEN_LO: begin
               len_n   = {8'h00, bus.rx_data_i};
               state_n = LEN_HI;
            end
            LEN_HI: begin
               len_n = len_full;
               if (len_full == 16'd0) begin
                  state_n = CSUM;
               end else if (32'(len_full) > MAX_WORDS) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  err_n   = 1'b1;
               end else begin
                  state_n = DATA;
               end
            end
            DATA: begin
               // Bytes arrive LSB first, so shifting in from the top leaves {b3,b2,b1,b0}.
               word_n     = {bus.rx_data_i, word[31:8]};
               csum_n     = csum + bus.rx_data_i;
               byte_idx_n = byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  wr_en_n    = 1'b1;
                  wr_data_n  = word_n;
                  wr_addr_n  = BASE_ADDR + {14'd0, word_cnt, 2'b00};
                  word_cnt_n = word_cnt + 16'd1;
                  if (word_cnt_n == len) begin
                     state_n = CSUM;
                  end
               end
            end
            CSUM: begin
               state_n = IDLE;
               busy_n  = 1'b0;
               if (bus.rx_data_i == csum) begin
                  done_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_en_o    = wr_en;
   assign bus.wr_addr_o  = wr_addr;
   assign bus.wr_data_o  = wr_data;
   assign bus.busy_o     = busy;
   assign bus.cpu_hold_o = busy;
   assign bus.done_o     = done;
   assign bus.err_o      = err;

endmodule
